circle_sprite_engine: RTL and testbench

Parametrised pixel-colour generator for the 96x64 OLED path. It renders up to NUM_CIRCLES filled or ring-shaped circles, each with its own radius and colour, over a background colour. Optionally the circles bounce around the screen, one step per FRAME_DIV frames. It sits between the OLED driver's pixel_index output and its pixel_data input, and supersedes the single fixed-position circle generator.

---
 rtl/circle_sprite_engine_if.sv | 9 +
 rtl/circle_sprite_engine.sv | 169 ++++++++++++++++
 tb/tb_circle_sprite_engine.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/circle_sprite_engine_if.sv
// rtl/circle_sprite_engine_if.sv - pixel index in, pixel colour and frame tick out
interface circle_sprite_engine_if;
   logic [12:0] pixel_index;
   logic [15:0] color;
   logic        frame_tick;

   modport master (output pixel_index, input color, input frame_tick);
   modport slave  (input pixel_index, output color, output frame_tick);
endinterface

// File: rtl/circle_sprite_engine.sv
// rtl/circle_sprite_engine.sv - renders bouncing filled/ring circles over a background
// Two-stage pixel pipeline plus per-frame motion of each circle centre.
module circle_sprite_engine #(
   parameter int WIDTH       = 96,
   parameter int HEIGHT      = 64,
   parameter int NUM_CIRCLES = 2,
   parameter int RING_W      = 2,
   parameter int FRAME_DIV   = 2
) (
   input  logic                      clk25,
   input  logic                      rst_n,
   circle_sprite_engine_if.slave     pix,
   input  logic                      move_en,
   input  logic                      ring_mode,
   input  logic [6*NUM_CIRCLES-1:0]  radius,
   input  logic [16*NUM_CIRCLES-1:0] circle_color,
   input  logic [15:0]               bg_color
);
   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
   localparam int R_MAX = HEIGHT / 2 - 1;
   localparam int NPIX  = WIDTH * HEIGHT;

   logic [12:0]      idx_q, idx_d;
   logic             frame_tick_q, frame_tick_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic             step;
   logic [6:0]       cx_q [NUM_CIRCLES];
   logic [6:0]       cx_d [NUM_CIRCLES];
   logic [5:0]       cy_q [NUM_CIRCLES];
   logic [5:0]       cy_d [NUM_CIRCLES];
   logic             dirx_q [NUM_CIRCLES];
   logic             dirx_d [NUM_CIRCLES];
   logic             diry_q [NUM_CIRCLES];
   logic             diry_d [NUM_CIRCLES];
   logic [6:0]       x_q, x_d;
   logic [5:0]       y_q, y_d;
   logic             valid_q, valid_d;
   logic [15:0]      color_q, color_d;

   function automatic logic [6:0] cx_init(input int k);
      return 7'((k + 1) * WIDTH / (NUM_CIRCLES + 1));
   endfunction

   function automatic logic [5:0] r_eff(input logic [5:0] r);
      return (r > 6'(R_MAX)) ? 6'(R_MAX) : r;
   endfunction

   // Near-edge check wins over far-edge so an oversized circle drifts toward +.
   function automatic void axis_step(input logic [6:0] pos, input logic dir,
                                     input logic [5:0] r, input logic signed [9:0] lim,
                                     output logic [6:0] pos_n, output logic dir_n);
      logic signed [9:0] np;
      np    = $signed({3'b000, pos}) + (dir ? 10'sd1 : -10'sd1);
      pos_n = pos;
      dir_n = dir;
      if (np - $signed({4'b0000, r}) < 10'sd0) begin
         dir_n = 1'b1;
      end else if (np + $signed({4'b0000, r}) > lim) begin
         dir_n = 1'b0;
      end else begin
         pos_n = np[6:0];
      end
   endfunction

   always_comb begin : motion
      logic [6:0] cy_n;
      cy_n         = '0;
      idx_d        = pix.pixel_index;
      frame_tick_d = (pix.pixel_index == 13'd0) && (idx_q != 13'd0);
      fcnt_d       = fcnt_q;
      step         = 1'b0;
      if (frame_tick_q) begin
         if (fcnt_q == CNT_LAST) begin
            fcnt_d = '0;
            step   = move_en;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
      for (int k = 0; k < NUM_CIRCLES; k++) begin
         cx_d[k]   = cx_q[k];
         cy_d[k]   = cy_q[k];
         dirx_d[k] = dirx_q[k];
         diry_d[k] = diry_q[k];
         if (step) begin
            axis_step(cx_q[k], dirx_q[k], r_eff(radius[6*k +: 6]), 10'(WIDTH - 1),
                      cx_d[k], dirx_d[k]);
            axis_step({1'b0, cy_q[k]}, diry_q[k], r_eff(radius[6*k +: 6]), 10'(HEIGHT - 1),
                      cy_n, diry_d[k]);
            cy_d[k] = cy_n[5:0];
         end
      end
   end

   always_comb begin : s1
      x_d     = 7'(pix.pixel_index % WIDTH);
      y_d     = 6'(pix.pixel_index / WIDTH);
      valid_d = int'(pix.pixel_index) < NPIX;
   end

   // Walk from the highest index down so the lowest-index hit ends up winning.
   always_comb begin : s2
      logic signed [15:0] dx, dy;
      logic [13:0]        d2, rr, ri;
      logic [5:0]         r;
      logic               hit;
      dx      = '0;
      dy      = '0;
      d2      = '0;
      rr      = '0;
      ri      = '0;
      r       = '0;
      hit     = 1'b0;
      color_d = bg_color;
      if (valid_q) begin
         for (int k = NUM_CIRCLES - 1; k >= 0; k--) begin
            dx  = $signed({9'b0, x_q}) - $signed({9'b0, cx_q[k]});
            dy  = $signed({10'b0, y_q}) - $signed({10'b0, cy_q[k]});
            d2  = 14'(dx * dx) + 14'(dy * dy);
            r   = r_eff(radius[6*k +: 6]);
            rr  = {8'b0, r};
            ri  = {8'b0, 6'(r - 6'(RING_W))};
            hit = d2 <= rr * rr;
            if (ring_mode && (r >= 6'(RING_W))) begin
               hit = hit && (d2 > ri * ri);
            end
            if (hit) begin
               color_d = circle_color[16*k +: 16];
            end
         end
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         frame_tick_q <= 1'b0;
         fcnt_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         valid_q      <= 1'b0;
         color_q      <= '0;
         for (int k = 0; k < NUM_CIRCLES; k++) begin
            cx_q[k]   <= cx_init(k);
            cy_q[k]   <= 6'(HEIGHT / 2);
            dirx_q[k] <= (k % 2 == 0);
            diry_q[k] <= 1'b1;
         end
      end else begin
         idx_q        <= idx_d;
         frame_tick_q <= frame_tick_d;
         fcnt_q       <= fcnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         valid_q      <= valid_d;
         color_q      <= color_d;
         for (int k = 0; k < NUM_CIRCLES; k++) begin
            cx_q[k]   <= cx_d[k];
            cy_q[k]   <= cy_d[k];
            dirx_q[k] <= dirx_d[k];
            diry_q[k] <= diry_d[k];
         end
      end
   end

   assign pix.color      = color_q;
   assign pix.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_circle_sprite_engine.sv
// tb/tb_circle_sprite_engine.sv - randomized bench with a geometric reference model
module tb_circle_sprite_engine;
   localparam int W  = 96;
   localparam int H  = 64;
   localparam int NC = 2;
   localparam int RW = 2;
   localparam int FD = 2;

   logic            clk25 = 1'b0;
   logic            rst_n;
   logic            move_en;
   logic            ring_mode;
   logic [6*NC-1:0] radius;
   logic [16*NC-1:0] circle_color;
   logic [15:0]     bg_color;

   circle_sprite_engine_if pif ();

   circle_sprite_engine #(.WIDTH(W), .HEIGHT(H), .NUM_CIRCLES(NC), .RING_W(RW), .FRAME_DIV(FD)) dut (
      .clk25        (clk25),
      .rst_n        (rst_n),
      .pix          (pif),
      .move_en      (move_en),
      .ring_mode    (ring_mode),
      .radius       (radius),
      .circle_color (circle_color),
      .bg_color     (bg_color)
   );

   always #20 clk25 = ~clk25;

   int n_checks = 0;
   int n_pass   = 0;

   int          rad  [NC];
   logic [15:0] col  [NC];
   int          m_cx [NC];
   int          m_cy [NC];
   int          m_dx [NC];
   int          m_dy [NC];
   int          m_cnt;
   int          prev_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int xy(input int x, input int y);
      return y * W + x;
   endfunction

   task automatic apply_cfg();
      for (int k = 0; k < NC; k++) begin
         radius[6*k +: 6]        = 6'(rad[k]);
         circle_color[16*k +: 16] = col[k];
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NC; k++) begin
         m_cx[k] = (k + 1) * W / (NC + 1);
         m_cy[k] = H / 2;
         m_dx[k] = (k % 2 == 0) ? 1 : -1;
         m_dy[k] = 1;
      end
      m_cnt    = 0;
      prev_idx = 0;
   endtask

   function automatic int clamp_r(input int r);
      return (r > H / 2 - 1) ? H / 2 - 1 : r;
   endfunction

   task automatic bounce(inout int c, inout int d, input int r, input int lim);
      int n;
      n = c + d;
      if (n - r < 0) d = 1;
      else if (n + r > lim) d = -1;
      else c = n;
   endtask

   task automatic model_step();
      for (int k = 0; k < NC; k++) begin
         bounce(m_cx[k], m_dx[k], clamp_r(rad[k]), W - 1);
         bounce(m_cy[k], m_dy[k], clamp_r(rad[k]), H - 1);
      end
   endtask

   function automatic logic [15:0] model_color(input int p);
      int x, y, r, d2;
      if (p >= W * H) return bg_color;
      x = p % W;
      y = p / W;
      for (int k = 0; k < NC; k++) begin
         r  = clamp_r(rad[k]);
         d2 = (x - m_cx[k]) * (x - m_cx[k]) + (y - m_cy[k]) * (y - m_cy[k]);
         if (d2 <= r * r) begin
            if (!(ring_mode && r >= RW && d2 <= (r - RW) * (r - RW))) return col[k];
         end
      end
      return bg_color;
   endfunction

   task automatic drive(input int p);
      logic exp_tick;
      exp_tick = (p == 0) && (prev_idx != 0);
      pif.pixel_index = 13'(p);
      @(negedge clk25);
      chk("frame_tick", {31'b0, pif.frame_tick}, {31'b0, exp_tick});
      if (exp_tick) begin
         if (m_cnt == FD - 1) begin
            m_cnt = 0;
            if (move_en) model_step();
         end else begin
            m_cnt++;
         end
      end
      prev_idx = p;
   endtask

   task automatic show(input string tag, input int p);
      drive(p);
      drive(p);
      drive(p);
      chk(tag, {16'b0, pif.color}, {16'b0, model_color(p)});
   endtask

   task automatic do_reset();
      @(posedge clk25);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_color", {16'b0, pif.color}, 32'd0);
      chk("rst_tick", {31'b0, pif.frame_tick}, 32'd0);
      @(negedge clk25);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks;
      rst_n           = 1'b0;
      pif.pixel_index = '0;
      move_en         = 1'b0;
      ring_mode       = 1'b0;
      bg_color        = 16'($urandom);
      col[0]          = bg_color ^ 16'h00FF;
      col[1]          = bg_color ^ 16'hFF00;
      rad[0]          = 8;
      rad[1]          = 8;
      apply_cfg();
      model_reset();
      repeat (3) @(negedge clk25);
      chk("reset_color", {16'b0, pif.color}, 32'd0);
      chk("reset_tick", {31'b0, pif.frame_tick}, 32'd0);
      rst_n = 1'b1;

      show("c0_centre", xy(32, 32));
      show("c1_centre", xy(64, 32));
      show("index0_bg", 0);
      for (int i = 0; i < 30; i++) show("static_rand", $urandom_range(W * H - 1, 0));

      show("disc_edge_in", xy(40, 32));
      show("disc_edge_out", xy(41, 32));
      show("disc_diag_out", xy(38, 38));
      rad[0] = 0;
      apply_cfg();
      show("r0_centre", xy(32, 32));
      show("r0_right", xy(33, 32));
      show("r0_below", xy(32, 33));

      rad[0] = 8;
      ring_mode = 1'b1;
      apply_cfg();
      show("ring_centre", xy(32, 32));
      show("ring_inner", xy(38, 32));
      show("ring_39", xy(39, 32));
      show("ring_40", xy(40, 32));
      rad[0] = 1;
      apply_cfg();
      show("ring_r1_centre", xy(32, 32));
      show("ring_r1_edge", xy(33, 32));

      for (int i = 0; i < 40; i++) begin
         ring_mode = 1'($urandom);
         rad[0] = $urandom_range(63, 0);
         rad[1] = $urandom_range(63, 0);
         apply_cfg();
         show("rand_geom", $urandom_range(W * H - 1, 0));
      end

      ring_mode = 1'b0;
      rad[0] = 31;
      rad[1] = 31;
      apply_cfg();
      show("priority", xy(48, 32));

      show("oor_6144", 6144);
      show("oor_8191", 8191);
      for (int i = 0; i < 10; i++) show("oor_rand", $urandom_range(8191, 6144));

      ticks = 0;
      drive(6143); ticks += int'(pif.frame_tick);
      drive(0);    ticks += int'(pif.frame_tick);
      drive(0);    ticks += int'(pif.frame_tick);
      drive(1);    ticks += int'(pif.frame_tick);
      drive(0);    ticks += int'(pif.frame_tick);
      drive(5);
      chk("tick_pulses", 32'(ticks), 32'd2);

      drive(xy(50, 20));
      do_reset();

      rad[0] = 8;
      rad[1] = 8;
      apply_cfg();
      move_en = 1'b1;
      drive(7);
      for (int f = 0; f < 240; f++) begin
         drive(0);
         drive(7);
         show("mv_c0_centre", xy(m_cx[0], m_cy[0]));
         show("mv_c0_right", xy((m_cx[0] + 9 > W - 1) ? W - 1 : m_cx[0] + 9, m_cy[0]));
         show("mv_c1_bottom", xy(m_cx[1], (m_cy[1] + 8 > H - 1) ? H - 1 : m_cy[1] + 8));
         show("mv_rand", $urandom_range(W * H - 1, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
